// File: rtl/uart_cmd_parser.sv
// UART command framer: HDR, CMD, LEN_H, LEN_L [, CHK] -> one launch to the FIFO controller.
// Optional checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_parser #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0] CMD_MAX     = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_busy,
  input  logic        fifo_done,
  output logic [7:0]  cmd,
  output logic [15:0] rx_cnt,
  output logic        en_fc,
  output logic        fe_done,
  output logic        parser_busy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    HUNT, CMD, LEN_H, LEN_L, CHK, ISSUE, BUSY, RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sh_cmd_q;
  logic [15:0]   sh_len_q;
  logic [TW-1:0] idle_q;
  logic [7:0]    cmd_q, err_cnt_q;
  logic [15:0]   rx_cnt_q;
  logic          en_fc_q, fe_done_q, parser_busy_q, frame_err_q;
  logic          drop_d, launch_d, in_frame_q, in_frame_d, timeout_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  function automatic logic cmd_legal(input logic [7:0] c);
    return (c != 8'h00) && (c <= CMD_MAX);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  assign in_frame_q = (state_q == CMD) || (state_q == LEN_H) ||
                      (state_q == LEN_L) || (state_q == CHK);
  assign in_frame_d = (state_d == CMD) || (state_d == LEN_H) ||
                      (state_d == LEN_L) || (state_d == CHK);
  // A byte in the terminal idle cycle is consumed, so timeout needs !rx_valid.
  assign timeout_d  = in_frame_q && !rx_valid && (idle_q == IDLE_LAST);

  always_comb begin
    state_d  = state_q;
    drop_d   = 1'b0;
    launch_d = 1'b0;
    case (state_q)
      HUNT:  if (rx_valid && rx_data == HDR_BYTE) state_d = CMD;
      CMD:   if (rx_valid) state_d = LEN_H;
      LEN_H: if (rx_valid) state_d = LEN_L;
      LEN_L: if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
        state_d = CHK;
`else
        if (cmd_legal(sh_cmd_q)) state_d = ISSUE;
        else                     drop_d  = 1'b1;
`endif
      end
`ifdef UART_CMD_CHECKSUM_EN
      CHK:   if (rx_valid) begin
        if (rx_data == xor_q && cmd_legal(sh_cmd_q)) state_d = ISSUE;
        else                                         drop_d  = 1'b1;
      end
`endif
      ISSUE: if (!fifo_busy) begin
        launch_d = 1'b1;
        state_d  = BUSY;
      end
      BUSY:    if (fifo_done) state_d = RELEASE;
      RELEASE: if (!fifo_busy) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (timeout_d) drop_d = 1'b1;
    if (drop_d)    state_d = HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      sh_cmd_q      <= '0;
      sh_len_q      <= '0;
      idle_q        <= '0;
      cmd_q         <= '0;
      rx_cnt_q      <= '0;
      en_fc_q       <= 1'b0;
      fe_done_q     <= 1'b0;
      parser_busy_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      parser_busy_q <= (state_d != HUNT);
      en_fc_q       <= launch_d;
      frame_err_q   <= drop_d;

      if (rx_valid || !in_frame_d) idle_q <= '0;
      else                         idle_q <= idle_q + TW'(1);

      if (drop_d) begin
        sh_cmd_q  <= '0;
        sh_len_q  <= '0;
        err_cnt_q <= sat_inc(err_cnt_q);
`ifdef UART_CMD_CHECKSUM_EN
        xor_q     <= '0;
`endif
      end else if (rx_valid) begin
        case (state_q)
          CMD: begin
            sh_cmd_q <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q    <= rx_data;
`endif
          end
          LEN_H: begin
            sh_len_q[15:8] <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q          <= xor_q ^ rx_data;
`endif
          end
          LEN_L: begin
            sh_len_q[7:0] <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q         <= xor_q ^ rx_data;
`endif
          end
          default: ;
        endcase
      end

      // fe_done stays high from launch until the controller reports done.
      if (launch_d) begin
        cmd_q     <= sh_cmd_q;
        rx_cnt_q  <= sh_len_q;
        fe_done_q <= 1'b1;
      end else if (state_q == BUSY && fifo_done) begin
        fe_done_q <= 1'b0;
      end
    end
  end

  assign cmd         = cmd_q;
  assign rx_cnt      = rx_cnt_q;
  assign en_fc       = en_fc_q;
  assign fe_done     = fe_done_q;
  assign parser_busy = parser_busy_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Front-end command parser sitting directly upstream of the FIFO controller. It consumes bytes from the UART receiver, frames them into host commands, and presents a validated command to the controller:
- `cmd` and `rx_cnt` are held stable;
- `en_fc` is a one-cycle launch pulse;
- `fe_done` drops as the completion acknowledge.

It holds off new frames until the controller has returned to idle. Malformed, unsupported and timed-out frames are dropped and counted.

## Interface
- `HDR_BYTE`, 8'hA5: frame header byte.
- `TIMEOUT_CYC`, 50000: max clk cycles between bytes of one frame (1 ms at 50 MHz).
- `CMD_MAX`, 8'h04: highest legal command code; legal codes are 8'h01..`CMD_MAX`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `fifo_busy`  in  1  controller not idle.
- `fifo_done`  in  1  controller in done state.
- `cmd`  out  8  accepted command code.
- `rx_cnt`  out  16  accepted length field.
- `en_fc`  out  1  one-cycle command launch pulse.
- `fe_done`  out  1  high while a command is in flight; its falling edge releases the controller.
- `parser_busy`  out  1  state ≠ HUNT.
- `frame_err`  out  1  one-cycle pulse on a dropped frame.
- `err_cnt`  out  8  dropped-frame count, saturating at 8'hFF.

## Operation
States: HUNT, CMD, LEN_H, LEN_L, CHK, ISSUE, BUSY, RELEASE.
- **HUNT**
  - `rx_valid` with `rx_data`==`HDR_BYTE` → CMD.
  - Any other byte is discarded silently; it is not counted as an error.
- **CMD**
  - Byte latched into the shadow command register → LEN_H.
- **LEN_H / LEN_L**
  - Length is big-endian: `{LEN_H, LEN_L}` forms a 16-bit value.
  - LEN_L → CHK when the checksum is compiled in, otherwise → ISSUE.
- **CHK**
  - Compare against the running XOR of cmd, len_h and len_l.
  - Match → ISSUE.
  - Mismatch → error → HUNT.
- **Command legality**
  - Checked on entry to ISSUE.
  - Code 0, or a code greater than `CMD_MAX` → error → HUNT.
- **ISSUE**
  - When `fifo_busy`==0: copy the shadow registers to `cmd`/`rx_cnt`, pulse `en_fc` for one cycle, set `fe_done`=1, → BUSY.
  - While `fifo_busy`==1: wait; no timeout applies.
- **BUSY**
  - Bytes arriving here are payload for the FIFO path and are ignored.
  - `fifo_done`==1 → clear `fe_done` → RELEASE.
- **RELEASE**
  - `fifo_busy`==0 → HUNT.
- **Timeout**
  - In CMD..CHK, an idle counter increments every cycle without `rx_valid` and reloads to 0 on `rx_valid`.
  - Reaching `TIMEOUT_CYC`-1 → error → HUNT.
- **Error action**
  - `frame_err` pulses for one cycle.
  - `err_cnt` increments and saturates at 8'hFF.
  - Shadow registers are cleared.
  - `cmd`/`rx_cnt` are untouched.
- **Output hold**
  - `cmd`/`rx_cnt` keep the last issued values until the next ISSUE.
- **Reset (mid-frame or mid-command)**
  - All state and outputs are cleared immediately; the state returns to HUNT.

## Timing
- **Reset values:** `cmd`=0, `rx_cnt`=0, `en_fc`=0, `fe_done`=0, `parser_busy`=0, `frame_err`=0, `err_cnt`=0.
- **Outputs:** all are registered; there are no combinational paths from input to output.
- **Issue latency:** `en_fc` asserts on the clock edge after the cycle in which ISSUE is occupied with `fifo_busy`==0.
  - `cmd`/`rx_cnt` are valid on that same edge.
- **Completion latency:** `fe_done` falls one clock after `fifo_done` is first sampled high.
  - The controller detects that falling edge through its two-flop synchroniser.
- **Byte in ISSUE:** an `rx_valid` arriving in the same cycle as the ISSUE transition is ignored.
- **Timeout vs. byte:** `rx_valid` in the terminal timeout cycle wins; the byte is consumed and no error is raised.
- **`err_cnt`** updates on the same edge as `frame_err`.

## Configuration
- `UART_CMD_CHECKSUM_EN` **defined:**
  - The frame is 5 bytes: HDR, CMD, LEN_H, LEN_L, CHK, where CHK = CMD^LEN_H^LEN_L.
  - The CHK state and its mismatch error are present.
- `UART_CMD_CHECKSUM_EN` **undefined:**
  - The frame is 4 bytes.
  - The CHK state and its XOR register are not synthesised.
  - LEN_L → ISSUE directly.

## Test plan
- **Valid frame:** A5 01 00 10 (+11 with checksum), `fifo_busy`=0 → one `en_fc` pulse; `cmd`=01, `rx_cnt`=0x0010, `fe_done`=1; then `fifo_done`=1 → `fe_done`=0 next cycle, back to HUNT after `fifo_busy`=0.
- **Garbage before header:** 00 FF A5 03 00 00 (+03) → `cmd`=03, `rx_cnt`=0, `err_cnt` stays 0.
- **Illegal code and bad checksum:**
  - A5 07 00 01 → `frame_err` pulse, `err_cnt`=1, no `en_fc`.
  - With the checksum compiled in, A5 02 00 01 00 → `err_cnt`=1, no `en_fc`.
- **Timeout:** A5 01 then silence for `TIMEOUT_CYC` cycles → `frame_err`, back to HUNT.
  - A byte landing exactly on the last cycle → no error.
- **Busy hold-off:** frame completes while `fifo_busy`=1 for 200 cycles → `en_fc` pulses exactly once, on the cycle after `fifo_busy` falls.
  - Payload bytes sent during BUSY are ignored.
- **Reset mid-frame:** `rst` pulse after A5 04 → all outputs at reset values; a following full frame A5 04 00 00 (+04) issues normally.
- **`err_cnt` saturation:** 300 bad frames → `err_cnt`=FF.
